// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier.
// Holds the default operand width and the FSM state encoding.
package mult_pkg;

    localparam int MULT_WIDTH = 16;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    typedef enum logic {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT
    } mult_state_e;

    function automatic int cnt_bits(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/mult_core.sv
// Sequential unsigned shift-and-add multiplier, one multiplier bit per clock.
// Fixed latency of WIDTH cycles from the start edge to done.
module mult_core
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic [2*WIDTH-1:0] result,
    output logic               done,
    output logic               busy
);

    localparam int CW = cnt_bits(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    mult_state_e      state;
    logic             init_q;
    logic [2*WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [CW-1:0]    cnt;
    logic             start;

    assign start = init & ~init_q & (state == S_IDLE);

    always_comb begin
        acc_nxt = acc;
        if (sb[0]) begin
            acc_nxt = acc + sa;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            init_q <= 1'b0;
            sa     <= '0;
            sb     <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            // init_q tracks in every state so an edge seen mid-op is consumed
            init_q <= init;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        sa     <= {{WIDTH{1'b0}}, op_a};
                        sb     <= op_b;
                        acc    <= '0;
                        cnt    <= '0;
                        result <= '0;
                        done   <= 1'b0;
                        busy   <= 1'b1;
                        state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    acc <= acc_nxt;
                    sa  <= sa << 1;
                    sb  <= sb >> 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        result <= acc_nxt;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_core.sv
// Directed-vector bench for mult_core at the default 16-bit width.
// Inputs change 1 time unit after a rising edge; outputs are read there too.
module tb_mult_core;

    logic        clk;
    logic        rst;
    logic        init;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [31:0] result;
    logic        done;
    logic        busy;

    int n_chk;
    int n_err;

    mult_core #(.WIDTH(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .init   (init),
        .op_a   (op_a),
        .op_b   (op_b),
        .result (result),
        .done   (done),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] a, input logic [15:0] b);
        init = 1'b0;
        step();
        op_a = a;
        op_b = b;
        init = 1'b1;
        step();
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_done", {31'd0, done}, 32'd0);
        chk("start_res", result, 32'd0);
    endtask

    task automatic wait_done(input string tag, input logic [31:0] exp);
        repeat (15) step();
        chk({tag, "_early"}, {31'd0, done}, 32'd0);
        step();
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_res"}, result, exp);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst   = 1'b0;
        init  = 1'b0;
        op_a  = '0;
        op_b  = '0;
        #2;
        chk("rst_res", result, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        step();
        step();
        rst = 1'b1;
        step();

        // 5 x 15
        do_start(16'h0005, 16'h000F);
        wait_done("t1", 32'h0000_004B);

        // max x max, init held high afterwards
        do_start(16'hFFFF, 16'hFFFF);
        wait_done("t2", 32'hFFFE_0001);
        repeat (5) step();
        chk("t2_hold_done", {31'd0, done}, 32'd1);
        chk("t2_hold_busy", {31'd0, busy}, 32'd0);
        chk("t2_hold_res", result, 32'hFFFE_0001);

        // zero operands keep the fixed latency
        do_start(16'h1234, 16'h0000);
        wait_done("t3a", 32'd0);
        do_start(16'h0000, 16'h1234);
        wait_done("t3b", 32'd0);

        // init toggle and op_a change during SHIFT are ignored
        do_start(16'd3, 16'd7);
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 3) init = 1'b0;
            if (i == 4) begin
                init = 1'b1;
                op_a = 16'd9;
            end
            if (i == 15) chk("t4_early", {31'd0, done}, 32'd0);
        end
        chk("t4_done", {31'd0, done}, 32'd1);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_res", result, 32'h15);
        repeat (3) step();
        chk("t4_nobusy", {31'd0, busy}, 32'd0);
        chk("t4_keep", result, 32'h15);

        // async reset in the middle of an operation
        do_start(16'h00FF, 16'h0100);
        repeat (7) step();
        chk("t5_busy_pre", {31'd0, busy}, 32'd1);
        #3;
        rst  = 1'b0;
        init = 1'b0;
        #1;
        chk("t5_rst_res", result, 32'd0);
        chk("t5_rst_done", {31'd0, done}, 32'd0);
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        step();
        #2;
        rst = 1'b1;
        step();
        do_start(16'd2, 16'd3);
        wait_done("t5_after", 32'd6);

        // back-to-back: next edge right after done clears it
        do_start(16'h0010, 16'h0010);
        wait_done("t6", 32'h0000_0100);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=%0d", 1, 0);
        $fatal(1);
    end

endmodule
